// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: pixel strobe, pattern select and video output bundle
interface vga_pattern_gen_if #(
    parameter int COLOR_W = 4
);
    logic               pix_en;
    logic [1:0]         mode;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic               frame_start;
    modport master (output pix_en, mode, input r, g, b, hsync, vsync, de, frame_start);
    modport slave (input pix_en, mode, output r, g, b, hsync, vsync, de, frame_start);
endinterface

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA raster timing with four selectable test patterns
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int COLOR_W  = 4,
    parameter bit SYNC_POL = 1'b0,
    parameter int CHK_LOG2 = 5,
    parameter int BOX_SIZE = 64
) (
    input logic clk,
    input logic rst,
    vga_pattern_gen_if.slave bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW = $clog2(H_TOTAL);
    localparam int YW = $clog2(V_TOTAL);
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_VIS    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_FIRST = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_LAST  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [XW-1:0] BAR_W    = XW'(H_ACTIVE / 8);
    localparam logic [XW-1:0] BOX_W    = XW'(BOX_SIZE);
    localparam logic [XW-1:0] BOX_XMAX = XW'(H_ACTIVE - BOX_SIZE);
    localparam logic [XW-1:0] X_ONE    = XW'(1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_VIS    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_FIRST = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_LAST  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [YW-1:0] BOX_H    = YW'(BOX_SIZE);
    localparam logic [YW-1:0] BOX_YMAX = YW'(V_ACTIVE - BOX_SIZE);
    localparam logic [YW-1:0] Y_ONE    = YW'(1);
    // {r,g,b} per bar, index 0 = white down to index 7 = black
    localparam logic [7:0][2:0] BARS = {3'b000, 3'b001, 3'b100, 3'b101,
                                        3'b010, 3'b011, 3'b110, 3'b111};

    logic [XW-1:0]      h_cnt, box_x, nbox_x, cur_x, bar_q;
    logic [YW-1:0]      v_cnt, box_y, nbox_y, cur_y;
    logic               dir_x, dir_y, x_up, y_up;
    logic               frame, active, hs_win, vs_win, chk, in_box, mono;
    logic [1:0]         mode_q, cur_mode;
    logic [2:0]         bar_idx, bar_rgb;
    logic [COLOR_W-1:0] grad_r, grad_g, nr, ng, nb;

    // bounce the box: the step direction becomes the new travel direction
    always_comb begin
        x_up   = dir_x ? box_x != BOX_XMAX : box_x == '0;
        y_up   = dir_y ? box_y != BOX_YMAX : box_y == '0;
        nbox_x = x_up ? box_x + X_ONE : box_x - X_ONE;
        nbox_y = y_up ? box_y + Y_ONE : box_y - Y_ONE;
    end

    // pixel colour; on the frame-boundary pixel the freshly sampled mode and box apply
    always_comb begin
        frame    = bus.pix_en && h_cnt == '0 && v_cnt == '0;
        cur_mode = frame ? bus.mode : mode_q;
        cur_x    = frame ? nbox_x : box_x;
        cur_y    = frame ? nbox_y : box_y;
        active   = h_cnt < H_VIS && v_cnt < V_VIS;
        hs_win   = h_cnt >= HS_FIRST && h_cnt <= HS_LAST;
        vs_win   = v_cnt >= VS_FIRST && v_cnt <= VS_LAST;
        bar_q    = h_cnt / BAR_W;
        bar_idx  = bar_q > XW'(7) ? 3'd7 : bar_q[2:0];
        bar_rgb  = BARS[bar_idx];
        chk      = h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2];
        in_box   = h_cnt >= cur_x && h_cnt < cur_x + BOX_W && v_cnt >= cur_y && v_cnt < cur_y + BOX_H;
        mono     = cur_mode[1] ? in_box : chk;
        grad_r   = COLOR_W'(h_cnt >> (XW - COLOR_W));
        grad_g   = COLOR_W'(v_cnt >> (YW - COLOR_W));
        nr = !active ? '0 : cur_mode == 2'd0 ? {COLOR_W{bar_rgb[2]}} : cur_mode == 2'd2 ? grad_r : {COLOR_W{mono}};
        ng = !active ? '0 : cur_mode == 2'd0 ? {COLOR_W{bar_rgb[1]}} : cur_mode == 2'd2 ? grad_g : {COLOR_W{mono}};
        nb = !active || cur_mode == 2'd2 ? '0 : cur_mode == 2'd0 ? {COLOR_W{bar_rgb[0]}} : {COLOR_W{mono}};
    end

    // raster counters advance one pixel per strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (bus.pix_en) begin
            h_cnt <= h_cnt == H_LAST ? '0 : h_cnt + X_ONE;
            if (h_cnt == H_LAST) v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + Y_ONE;
        end
    end

    // mode and box position are only updated at the frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= '0;
            box_x  <= '0;
            box_y  <= '0;
            dir_x  <= 1'b1;
            dir_y  <= 1'b1;
        end else if (frame) begin
            mode_q <= bus.mode;
            box_x  <= nbox_x;
            box_y  <= nbox_y;
            dir_x  <= x_up;
            dir_y  <= y_up;
        end
    end

    // registered, mutually aligned video outputs; frame_start is a single-clk pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.r           <= '0;
            bus.g           <= '0;
            bus.b           <= '0;
            bus.de          <= 1'b0;
            bus.hsync       <= ~SYNC_POL;
            bus.vsync       <= ~SYNC_POL;
            bus.frame_start <= 1'b0;
        end else begin
            bus.frame_start <= frame;
            if (bus.pix_en) begin
                bus.r     <= nr;
                bus.g     <= ng;
                bus.b     <= nb;
                bus.de    <= active;
                bus.hsync <= hs_win ? SYNC_POL : ~SYNC_POL;
                bus.vsync <= vs_win ? SYNC_POL : ~SYNC_POL;
            end
        end
    end
endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised VGA test-pattern generator with built-in raster timing. It replaces the fixed 1-bit RGB pattern logic with a self-contained block that has configurable resolution and porches, COLOR_W-bit colour channels, and four run-time-selectable patterns, one of them animated. It sits between the pixel-clock-enable source and the DAC/pin outputs. All outputs are registered and mutually aligned.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
- COLOR_W, 4, bits per colour channel; must be ≤ XW and ≤ YW
- SYNC_POL, 0, sync active level (0 = active-low)
- CHK_LOG2, 5, checkerboard square side = 2^CHK_LOG2 pixels
- BOX_SIZE, 64, moving-box side in pixels; must be < H_ACTIVE and < V_ACTIVE
- Derived: H_TOTAL = sum of H params; V_TOTAL = sum of V params; XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL)
- clk  in  1  system clock; one clock domain, no other clocks
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel strobe; the raster advances one pixel on each clk edge with pix_en=1
- mode  in  2  pattern select; sampled only at the frame boundary
- r, g, b  out  COLOR_W each  pixel colour; 0 outside the active area
- hsync, vsync  out  1  sync pulses at SYNC_POL level
- de  out  1  data enable; 1 during the active area
- frame_start  out  1  one-clk pulse that coincides with output of pixel (0,0)

## Operation
- Counters h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1. On pix_en, h_cnt increments. When h_cnt wraps to 0, v_cnt increments and wraps at V_TOTAL-1.
- pix_en=0: every register holds, including outputs, counters and box state. frame_start is 0 in any clk where pix_en=0.
- Active area: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Sync windows:
  - hsync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync is asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], for whole lines.
- Frame boundary is the pix_en cycle where h_cnt=0 and v_cnt=0. At that cycle:
  - mode_q <= mode.
  - The box position updates.
  - The frame_start output is set.
- Patterns use mode_q. "Full" means all ones.
  - Mode 0, colour bars: bar index = h_cnt / (H_ACTIVE/8), saturated at 7. Order is white, yellow, cyan, green, magenta, red, blue, black.
  - Mode 1, checkerboard: white when h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2] = 1, else black.
  - Mode 2, gradient: r = h_cnt >> (XW-COLOR_W), g = v_cnt >> (YW-COLOR_W), b = 0.
  - Mode 3, moving box: white inside [box_x, box_x+BOX_SIZE-1] × [box_y, box_y+BOX_SIZE-1], black elsewhere.
- Box motion: box_x and box_y each move ±1 per frame boundary.
  - Moving + at H_ACTIVE-BOX_SIZE (or V_ACTIVE-BOX_SIZE for y): reverse direction and step -1.
  - Moving - at 0: reverse direction and step +1.
  - The box never leaves the active area. The box moves in every mode, not only mode 3.

## Timing
- Latency is exactly one pix_en cycle. The outputs after edge k reflect the counter values before edge k.
- de, hsync, vsync, r, g, b and frame_start all change on the same edge, with no skew between them.
- Reset values:
  - Counters 0, mode_q 0.
  - box_x = box_y = 0, both directions +.
  - r, g, b = 0, de 0, frame_start 0.
  - hsync and vsync at the inactive level, ~SYNC_POL.
- Reset mid-frame: the next pix_en after rst is released outputs pixel (0,0) with frame_start=1.
- A mode change mid-frame has no visible effect until the next frame boundary. The new mode applies from pixel (0,0).
- Simultaneous rst and pix_en: rst wins.

## Test plan
- Reset, default params, pix_en tied high, mode=0 → frame_start every 800×525 = 420000 clks. hsync low for 96 clks starting at output pixel 656. vsync low for 2 lines starting at line 490. de high 640 clks per line.
- Mode 0 → at x=0 rgb=F/F/F. At x=80 rgb=F/F/0. At x=560 rgb=0/0/0. At x=639 rgb=0/0/0.
- Mode 2 → pixel (639,479) gives r=9, g=7, b=0. Blanking (x=700) gives r=g=b=0.
- Mode 3 over 578 frames → box_x sequence 0,1,…,576,575,…; it reverses exactly at 576. box_y reverses at 416. Pixel (box_x, box_y) is white and (box_x+64, box_y) is black.
- Mode changes 1→2 at line 100 → checkerboard continues to end of frame; gradient starts on the frame_start pixel.
- pix_en toggling 1-in-4 with rst pulsed at line 200 → outputs hold while pix_en=0. After rst: outputs return to their reset values, the box returns to (0,0), and the next enabled output is pixel (0,0) with frame_start=1.
